// File: rtl/sync_pkg.sv
// rtl/sync_pkg.sv - shared constants and types for the sync pulse link
// Purpose: word size, default pulse widths, decoder state encoding and width type.
// The sync generator imports the same package, so encoder and decoder constants agree.
package sync_pkg;

    localparam int NBITS       = 12;
    localparam int START_W_DEF = 2500;
    localparam int ONE_W_DEF   = 1250;
    localparam int ZERO_W_DEF  = 500;
    localparam int TOL_DEF     = 125;
    localparam int GAP_MAX_DEF = 2500;
    localparam int BCNT_W      = $clog2(NBITS);

    typedef logic [15:0]       width_t;
    typedef logic [NBITS-1:0]  word_t;
    typedef logic [BCNT_W-1:0] bitcnt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_GAP,
        ST_BIT,
        ST_DONE
    } state_t;

    // |w - x| <= tol, evaluated without going negative on the 16 b width type.
    function automatic logic in_window(input width_t w, input width_t x, input width_t tol);
        width_t d;
        d = (w >= x) ? (w - x) : (x - w);
        return (d <= tol);
    endfunction

endpackage

// File: rtl/sync_decoder_if.sv
// rtl/sync_decoder_if.sv - frame/sync inputs and decoded word outputs of the sync decoder
// Purpose: bundles the decoder's data-path signals.
// Ports:
//   frame_No    running frame number (driven by master)
//   sync_in     raw sync line (driven by master)
//   sec_out     last decoded word
//   frame_stamp frame number at the start pulse rising edge of sec_out
//   sec_vld     1-cycle pulse when sec_out/frame_stamp update
//   seq_err     1-cycle, with sec_vld: word is not previous+1
//   fmt_err     1-cycle: pulse width out of window or gap timeout
//   locked      two consecutive in-sequence words seen
interface sync_decoder_if;
    import sync_pkg::*;

    logic [31:0] frame_No;
    logic        sync_in;
    word_t       sec_out;
    logic [31:0] frame_stamp;
    logic        sec_vld;
    logic        seq_err;
    logic        fmt_err;
    logic        locked;

    modport master (
        output frame_No, sync_in,
        input  sec_out, frame_stamp, sec_vld, seq_err, fmt_err, locked
    );

    modport slave (
        input  frame_No, sync_in,
        output sec_out, frame_stamp, sec_vld, seq_err, fmt_err, locked
    );

endinterface

// File: rtl/sync_width_meter.sv
// rtl/sync_width_meter.sv - synchronizer, edge detect and frame-based pulse width counter
// Purpose: brings the async sync line into the clock domain, flags its edges and
//          measures time since the last edge in frames.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   i_frame_lsb   bit 0 of the running frame number
//   i_sync_in     raw asynchronous sync line
//   o_rise/o_fall single-cycle synced edge strobes
//   o_width       frames since the last synced edge, saturating
module sync_width_meter
    import sync_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_frame_lsb,
    input  logic   i_sync_in,
    output logic   o_rise,
    output logic   o_fall,
    output width_t o_width
);

    logic   r_sync1;
    logic   r_sync2;
    logic   r_sync3;
    logic   r_frame_lsb;
    width_t r_width;

    logic   w_tick;
    logic   w_rise;
    logic   w_fall;

    assign w_tick = i_frame_lsb ^ r_frame_lsb;
    assign w_rise = r_sync2 & ~r_sync3;
    assign w_fall = ~r_sync2 & r_sync3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_sync3     <= 1'b0;
            r_frame_lsb <= 1'b0;
            r_width     <= '0;
        end else begin
            r_sync1     <= i_sync_in;
            r_sync2     <= r_sync1;
            r_sync3     <= r_sync2;
            r_frame_lsb <= i_frame_lsb;
            // A tick landing on the clearing cycle is kept, so a pulse of N whole
            // frames always reads exactly N regardless of clock/frame phase.
            if (w_rise || w_fall) begin
                r_width <= {15'd0, w_tick};
            end else if (w_tick && (r_width != 16'hFFFF)) begin
                r_width <= r_width + 16'd1;
            end
        end
    end

    assign o_rise  = w_rise;
    assign o_fall  = w_fall;
    assign o_width = r_width;

endmodule

// File: rtl/sync_decoder.sv
// rtl/sync_decoder.sv - decodes start + NBITS pulse-width words from the behaviour-box sync line
// Purpose: recovers the second count, stamps each word with the frame of its start edge,
//          and tracks sequence continuity.
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   bus    sync_decoder_if.slave (frame_No, sync_in in; sec_out, frame_stamp,
//          sec_vld, seq_err, fmt_err, locked out)
module sync_decoder
    import sync_pkg::*;
#(
    parameter int START_W = START_W_DEF,
    parameter int ONE_W   = ONE_W_DEF,
    parameter int ZERO_W  = ZERO_W_DEF,
    parameter int TOL     = TOL_DEF,
    parameter int GAP_MAX = GAP_MAX_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    sync_decoder_if.slave  bus
);

    localparam width_t  LP_START   = width_t'(START_W);
    localparam width_t  LP_ONE     = width_t'(ONE_W);
    localparam width_t  LP_ZERO    = width_t'(ZERO_W);
    localparam width_t  LP_TOL     = width_t'(TOL);
    localparam width_t  LP_GAP_MAX = width_t'(GAP_MAX);
    localparam bitcnt_t LP_LAST    = bitcnt_t'(NBITS - 1);

    logic   w_rise;
    logic   w_fall;
    width_t w_width;

    logic   w_start_ok;
    logic   w_one_ok;
    logic   w_zero_ok;
    logic   w_seq_bad;
    word_t  w_expect;

    state_t      r_state;
    logic [31:0] r_stamp;
    word_t       r_shift;
    bitcnt_t     r_bitcnt;
    word_t       r_prev;
    logic        r_prev_vld;
    logic        r_chain;
    word_t       r_sec_out;
    logic [31:0] r_frame_stamp;
    logic        r_sec_vld;
    logic        r_seq_err;
    logic        r_fmt_err;
    logic        r_locked;

    sync_width_meter u_meter (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_frame_lsb (bus.frame_No[0]),
        .i_sync_in   (bus.sync_in),
        .o_rise      (w_rise),
        .o_fall      (w_fall),
        .o_width     (w_width)
    );

    always_comb begin
        w_start_ok = in_window(w_width, LP_START, LP_TOL);
        w_one_ok   = in_window(w_width, LP_ONE,   LP_TOL);
        w_zero_ok  = in_window(w_width, LP_ZERO,  LP_TOL);
        w_expect   = r_prev + word_t'(1);
        w_seq_bad  = r_prev_vld && (r_shift != w_expect);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_stamp       <= '0;
            r_shift       <= '0;
            r_bitcnt      <= '0;
            r_prev        <= '0;
            r_prev_vld    <= 1'b0;
            r_chain       <= 1'b0;
            r_sec_out     <= '0;
            r_frame_stamp <= '0;
            r_sec_vld     <= 1'b0;
            r_seq_err     <= 1'b0;
            r_fmt_err     <= 1'b0;
            r_locked      <= 1'b0;
        end else begin
            r_sec_vld <= 1'b0;
            r_seq_err <= 1'b0;
            r_fmt_err <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_stamp <= bus.frame_No;
                        r_state <= ST_START;
                    end
                end

                ST_START: begin
                    if (w_fall) begin
                        if (w_start_ok) begin
                            r_bitcnt <= '0;
                            r_state  <= ST_GAP;
                        end else begin
                            r_fmt_err <= 1'b1;
                            r_locked  <= 1'b0;
                            r_chain   <= 1'b0;
                            r_state   <= ST_IDLE;
                        end
                    end
                end

                ST_GAP: begin
                    if (w_rise) begin
                        r_state <= ST_BIT;
                    end else if (w_width > LP_GAP_MAX) begin
                        r_fmt_err <= 1'b1;
                        r_locked  <= 1'b0;
                        r_chain   <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end

                ST_BIT: begin
                    if (w_fall) begin
                        if (w_one_ok || w_zero_ok) begin
                            r_shift <= {r_shift[NBITS-2:0], w_one_ok};
                            if (r_bitcnt == LP_LAST) begin
                                r_state <= ST_DONE;
                            end else begin
                                r_bitcnt <= r_bitcnt + bitcnt_t'(1);
                                r_state  <= ST_GAP;
                            end
                        end else begin
                            r_fmt_err <= 1'b1;
                            r_locked  <= 1'b0;
                            r_chain   <= 1'b0;
                            r_state   <= ST_IDLE;
                        end
                    end
                end

                ST_DONE: begin
                    r_sec_out     <= r_shift;
                    r_frame_stamp <= r_stamp;
                    r_sec_vld     <= 1'b1;
                    r_seq_err     <= w_seq_bad;
                    r_prev        <= r_shift;
                    r_prev_vld    <= 1'b1;
                    // Any published word (even out of sequence) becomes the base the
                    // next word must follow; lock needs two words in a row that agree.
                    r_locked      <= !w_seq_bad && r_chain;
                    r_chain       <= 1'b1;
                    r_state       <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.sec_out     = r_sec_out;
    assign bus.frame_stamp = r_frame_stamp;
    assign bus.sec_vld     = r_sec_vld;
    assign bus.seq_err     = r_seq_err;
    assign bus.fmt_err     = r_fmt_err;
    assign bus.locked      = r_locked;

endmodule
